// File: rtl/dds_multi_osc.sv
// Time-multiplexed multi-channel DDS oscillator.
// One sample_tick starts a frame. The frame walks channels 0..NUM_CH-1 through a
// three-stage pipeline: fetch/phase update, waveform, then scale and accumulate.
// The saturated sum is then registered into mix_out_o.
// Ports:
//   clk_i, rst_active_high_i       : clock and asynchronous active-high reset
//   sample_tick_i                  : frame request, ignored while busy_o is high
//   cfg_we_i/cfg_ch_i/cfg_freq_i/
//   cfg_wave_i/cfg_amp_i           : per-channel config write (also clears that phase)
//   mix_out_o, mix_valid_o, busy_o : mixed sample, its update pulse, frame in progress
module dds_multi_osc #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned PHASE_WIDTH = 32,
    parameter int unsigned AMP_WIDTH   = 8
) (
    input  logic                                        clk_i,
    input  logic                                        rst_active_high_i,
    input  logic                                        sample_tick_i,
    input  logic                                        cfg_we_i,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] cfg_ch_i,
    input  logic [PHASE_WIDTH-1:0]                      cfg_freq_i,
    input  logic [1:0]                                  cfg_wave_i,
    input  logic [AMP_WIDTH-1:0]                        cfg_amp_i,
    output logic signed [15:0]                          mix_out_o,
    output logic                                        mix_valid_o,
    output logic                                        busy_o
);

    localparam int unsigned ChW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned AccW  = 16 + ChW + 1;
    localparam int unsigned ProdW = 17 + AMP_WIDTH;
    localparam logic [ChW-1:0]         LastCh = ChW'(NUM_CH - 1);
    localparam logic signed [AccW-1:0] SatHi  = AccW'(32767);
    localparam logic signed [AccW-1:0] SatLo  = AccW'(-32768);

    // 512-entry full-wave sine, amplitude 32767. The table is built at elaboration
    // from a Q30 Taylor series (through x^9) on the folded quarter wave.
    function automatic logic [16*512-1:0] gen_sine_rom();
        logic [16*512-1:0] rom;
        longint            x, x2, t, s, v;
        int                j;
        rom = '0;
        for (int k = 0; k < 512; k++) begin
            j = k % 256;
            if (j > 128) j = 256 - j;
            x  = longint'(j) * 64'sd13176795;   // 2*pi/512 in Q30
            x2 = (x * x) >>> 30;
            t  = 64'sd1073741824 - x2 / 64'sd72;
            t  = 64'sd1073741824 - ((x2 * t) >>> 30) / 64'sd42;
            t  = 64'sd1073741824 - ((x2 * t) >>> 30) / 64'sd20;
            t  = 64'sd1073741824 - ((x2 * t) >>> 30) / 64'sd6;
            s  = (x * t) >>> 30;
            v  = (s * 64'sd32767 + 64'sd536870912) >>> 30;
            if (k >= 256) v = -v;
            rom[k*16 +: 16] = v[15:0];
        end
        return rom;
    endfunction

    localparam logic [16*512-1:0] SineRom = gen_sine_rom();

    // Per-channel state
    logic [PHASE_WIDTH-1:0] phase_q [NUM_CH];
    logic [PHASE_WIDTH-1:0] freq_q  [NUM_CH];
    logic [1:0]             wave_q  [NUM_CH];
    logic [AMP_WIDTH-1:0]   amp_q   [NUM_CH];

    // Frame control and pipeline
    logic                   busy_q, run_q;
    logic [ChW-1:0]         ch_q;
    logic                   v1_q, last1_q, sine1_q;
    logic signed [15:0]     lut_q, nsv_q;
    logic [AMP_WIDTH-1:0]   amp1_q;
    logic                   v2_q, last2_q;
    logic signed [15:0]     s_q;
    logic signed [AccW-1:0] acc_q;
    logic signed [15:0]     mix_q;
    logic                   mix_valid_q;

    logic                   accept;
    logic [15:0]            p0;
    logic [14:0]            tri_u;
    logic signed [15:0]     lut_d, nsv_d, wave1;
    logic signed [ProdW-1:0] prod;
    logic signed [15:0]     s_d;
    logic signed [AccW-1:0] acc_d;
    logic signed [15:0]     sat_d;

    always_comb begin
        accept = sample_tick_i && !busy_q;
        p0     = phase_q[ch_q][PHASE_WIDTH-1 -: 16];
        tri_u  = p0[15] ? ~p0[14:0] : p0[14:0];
        lut_d  = SineRom[{p0[15:7], 4'b0000} +: 16];
        nsv_d  = '0;
        case (wave_q[ch_q])
            2'd1:    nsv_d = p0[15] ? 16'sh8000 : 16'sh7fff;
            2'd2:    nsv_d = p0 ^ 16'h8000;
            2'd3:    nsv_d = {tri_u, 1'b0} ^ 16'h8000;
            default: nsv_d = '0;
        endcase
        wave1 = sine1_q ? lut_q : nsv_q;
        prod  = ProdW'(wave1) * ProdW'($signed({1'b0, amp1_q}));
        s_d   = 16'(prod >>> AMP_WIDTH);
        acc_d = acc_q + AccW'(s_q);
        if (acc_d > SatHi) begin
            sat_d = 16'sh7fff;
        end else if (acc_d < SatLo) begin
            sat_d = 16'sh8000;
        end else begin
            sat_d = acc_d[15:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_active_high_i) begin
        if (rst_active_high_i) begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                phase_q[k] <= '0;
                freq_q[k]  <= '0;
                wave_q[k]  <= '0;
                amp_q[k]   <= '0;
            end
            busy_q      <= 1'b0;
            run_q       <= 1'b0;
            ch_q        <= '0;
            v1_q        <= 1'b0;
            last1_q     <= 1'b0;
            sine1_q     <= 1'b0;
            lut_q       <= '0;
            nsv_q       <= '0;
            amp1_q      <= '0;
            v2_q        <= 1'b0;
            last2_q     <= 1'b0;
            s_q         <= '0;
            acc_q       <= '0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
        end else begin
            mix_valid_q <= 1'b0;

            // Stage 0: fetch channel ch_q, advance its phase
            if (accept) begin
                busy_q <= 1'b1;
                run_q  <= 1'b1;
                ch_q   <= '0;
                acc_q  <= '0;
            end else if (run_q) begin
                ch_q <= ch_q + 1'b1;
                if (ch_q == LastCh) run_q <= 1'b0;
            end
            if (run_q) phase_q[ch_q] <= phase_q[ch_q] + freq_q[ch_q];

            // A config write lands after the write-back, so it wins a collision
            if (cfg_we_i) begin
                phase_q[cfg_ch_i] <= '0;
                freq_q[cfg_ch_i]  <= cfg_freq_i;
                wave_q[cfg_ch_i]  <= cfg_wave_i;
                amp_q[cfg_ch_i]   <= cfg_amp_i;
            end

            // Stage 1: LUT read, other waveforms delayed to match
            v1_q    <= run_q;
            last1_q <= run_q && (ch_q == LastCh);
            sine1_q <= (wave_q[ch_q] == 2'd0);
            lut_q   <= lut_d;
            nsv_q   <= nsv_d;
            amp1_q  <= amp_q[ch_q];

            // Stage 2: amplitude scaling
            v2_q    <= v1_q;
            last2_q <= v1_q && last1_q;
            s_q     <= s_d;

            // Accumulate; the last channel closes the frame
            if (v2_q) begin
                acc_q <= acc_d;
                if (last2_q) begin
                    mix_q       <= sat_d;
                    mix_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            end
        end
    end

    assign mix_out_o   = mix_q;
    assign mix_valid_o = mix_valid_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_dds_multi_osc.sv
module tb_dds_multi_osc;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sample_tick = 1'b0;
    logic               cfg_we = 1'b0;
    logic [1:0]         cfg_ch = '0;
    logic [31:0]        cfg_freq = '0;
    logic [1:0]         cfg_wave = '0;
    logic [7:0]         cfg_amp = '0;
    logic signed [15:0] mix_out;
    logic               mix_valid;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dds_multi_osc #(
        .NUM_CH     (4),
        .PHASE_WIDTH(32),
        .AMP_WIDTH  (8)
    ) dut (
        .clk_i            (clk),
        .rst_active_high_i(rst),
        .sample_tick_i    (sample_tick),
        .cfg_we_i         (cfg_we),
        .cfg_ch_i         (cfg_ch),
        .cfg_freq_i       (cfg_freq),
        .cfg_wave_i       (cfg_wave),
        .cfg_amp_i        (cfg_amp),
        .mix_out_o        (mix_out),
        .mix_valid_o      (mix_valid),
        .busy_o           (busy)
    );

    typedef struct {
        logic [1:0]  wave;
        logic [31:0] freq;
        logic [7:0]  amp;
        int          exp [4];
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input logic signed [31:0] act,
                             input int exp);
        int diff;
        n_tests++;
        diff = int'(act) - exp;
        if ($isunknown(act) || diff > 1 || diff < -1) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (+-1)", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic write_cfg(input logic [1:0] ch, input logic [1:0] w,
                             input logic [31:0] f, input logic [7:0] a);
        cfg_we = 1'b1; cfg_ch = ch; cfg_wave = w; cfg_freq = f; cfg_amp = a;
        step();
        cfg_we = 1'b0;
    endtask

    // Tick in the current cycle, then wait (bounded) for mix_valid
    task automatic run_frame(output logic signed [31:0] val, output int lat);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        lat = 1;
        while (mix_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        val = mix_out;
    endtask

    // Default (muted) frame with a dropped tick in T+3
    task automatic idle_frame(input string tag);
        bit busy_ok;
        int pulses;
        busy_ok = 1'b1;
        pulses  = 0;
        sample_tick = 1'b1;
        step();
        for (int c = 1; c <= 6; c++) begin
            if (busy !== 1'b1 || mix_valid !== 1'b0) busy_ok = 1'b0;
            sample_tick = (c == 3);
            step();
        end
        sample_tick = 1'b0;
        check({tag, "_busy_window"}, busy_ok, 1);
        check({tag, "_valid_t7"}, mix_valid, 1);
        check({tag, "_mix_t7"}, mix_out, 0);
        check({tag, "_busy_t7"}, busy, 0);
        for (int c = 0; c < 12; c++) begin
            step();
            if (mix_valid === 1'b1) pulses++;
        end
        check({tag, "_no_extra_pulse"}, pulses, 0);
    endtask

    task automatic set_vec(input int i, input logic [1:0] w, input logic [31:0] f,
                           input logic [7:0] a, input int e0, input int e1,
                           input int e2, input int e3);
        vecs[i].wave   = w;
        vecs[i].freq   = f;
        vecs[i].amp    = a;
        vecs[i].exp[0] = e0;
        vecs[i].exp[1] = e1;
        vecs[i].exp[2] = e2;
        vecs[i].exp[3] = e3;
    endtask

    function automatic int lut_ref(input int k);
        real r;
        r = 32767.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 512.0);
        return int'(r);
    endfunction

    initial begin
        logic signed [31:0] val;
        int                 lat;
        int                 pulses;

        // ch0 only; each write hard-syncs the phase, so every record starts at phase 0
        set_vec(0, 2'd1, 32'd0,       8'd255,  32639,  32639,  32639,  32639);
        set_vec(1, 2'd2, 32'h4000_0000, 8'd255, -32640, -16320,      0,  16320);
        // triangle at 0xC000 folds to 0x3FFF -> -2 after scaling
        set_vec(2, 2'd3, 32'h4000_0000, 8'd255, -32640,      0,  32638,     -2);
        set_vec(3, 2'd1, 32'h8000_0000, 8'd255,  32639, -32640,  32639, -32640);
        set_vec(4, 2'd1, 32'd0,       8'd128,  16383,  16383,  16383,  16383);
        set_vec(5, 2'd2, 32'h4000_0000, 8'd0,        0,      0,      0,      0);
        set_vec(6, 2'd2, 32'h2000_0000, 8'd255, -32640, -24480, -16320,  -8160);
        set_vec(7, 2'd3, 32'h8000_0000, 8'd128, -16384,  16383, -16384,  16383);

        // Reset state and a default frame
        do_reset();
        check("rst_mix_out", mix_out, 0);
        check("rst_mix_valid", mix_valid, 0);
        check("rst_busy", busy, 0);
        idle_frame("idle");

        // Table-driven single-channel waveforms
        for (int i = 0; i < 8; i++) begin
            write_cfg(2'd0, vecs[i].wave, vecs[i].freq, vecs[i].amp);
            for (int f = 0; f < 4; f++) begin
                run_frame(val, lat);
                check($sformatf("vec%0d_f%0d_lat", i, f), lat, 7);
                check($sformatf("vec%0d_f%0d_mix", i, f), val, vecs[i].exp[f]);
            end
        end

        // Saturation with all channels square
        do_reset();
        for (int c = 0; c < 4; c++) write_cfg(2'(c), 2'd1, 32'd0, 8'd255);
        for (int f = 0; f < 2; f++) begin
            run_frame(val, lat);
            check($sformatf("sat_hi_f%0d", f), val, 32767);
        end
        for (int c = 0; c < 4; c++) write_cfg(2'(c), 2'd1, 32'h8000_0000, 8'd255);
        for (int f = 0; f < 4; f++) begin
            run_frame(val, lat);
            check($sformatf("sat_alt_f%0d", f), val, (f % 2 == 0) ? 32767 : -32768);
        end

        // Write collision with ch0 entering the pipeline in T+1
        do_reset();
        write_cfg(2'd0, 2'd2, 32'h4000_0000, 8'd255);
        run_frame(val, lat);
        check("coll_prime", val, -32640);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        write_cfg(2'd0, 2'd3, 32'h4000_0000, 8'd255);
        lat = 2;
        while (mix_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check("coll_lat", lat, 7);
        check("coll_old_values", mix_out, -16320);
        run_frame(val, lat);
        check("coll_next_phase0", val, -32640);
        run_frame(val, lat);
        check("coll_next_phase1", val, 0);

        // Reset in T+3 aborts the frame
        do_reset();
        write_cfg(2'd0, 2'd1, 32'd0, 8'd255);
        run_frame(val, lat);
        check("abort_prime", val, 32639);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check("abort_mix_out", mix_out, 0);
        check("abort_mix_valid", mix_valid, 0);
        check("abort_busy", busy, 0);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (mix_valid === 1'b1) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        idle_frame("post_rst");

        // Sine sweep on ch1, one LUT address per frame, wrapping at 512
        do_reset();
        write_cfg(2'd1, 2'd0, 32'h0080_0000, 8'd255);
        for (int k = 0; k <= 512; k++) begin
            run_frame(val, lat);
            if (lat != 7) check($sformatf("sine_lat%0d", k), lat, 7);
            check_tol($sformatf("sine_k%0d", k), val, (lut_ref(k % 512) * 255) >>> 8);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
